// File: rtl/param_pack_stage_if.sv
// Purpose: narrow-beat in / wide-word out stream bundle for param_pack_stage.
// Latency: none, wires only.
// Backpressure: in_ready/out_ready per direction; master drives beats and accepts words.
// Ports: in_valid/in_ready/in_data/in_last (beat side), out_valid/out_ready/out_data/
//        out_lanes/out_last (word side). slave is the packer's view, master the peer's.
interface param_pack_stage_if #(
  parameter int W     = 4,
  parameter int RATIO = 2
);
  localparam int OW = W * RATIO;
  localparam int CW = $clog2(RATIO + 1);

  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_data;
  logic          in_last;
  logic          out_valid;
  logic          out_ready;
  logic [OW-1:0] out_data;
  logic [CW-1:0] out_lanes;
  logic          out_last;

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_lanes, out_last
  );

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_data, out_lanes, out_last
  );
endinterface

// File: rtl/param_pack_stage.sv
// Purpose: gearbox packing RATIO W-bit beats into one OW-bit word, buffered in a 2-entry FIFO.
// Latency: completing beat accepted at edge N shows up as out_valid after edge N.
// Backpressure: in_ready = FIFO not full (registered state only); out side is valid/ready.
// Ports: clk, rst_n (async active-low); bus (slave modport of param_pack_stage_if) carries
//        the beat input handshake and the packed word output handshake.

// Two-entry FIFO with 1-bit pointers. Push is ignored when full, pop when empty.
module pp_fifo2 #(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic [DW-1:0] push_dat,
  input  logic          pop,
  output logic [DW-1:0] head_dat,
  output logic [1:0]    count
);
  logic [DW-1:0] mem_q [2];
  logic [DW-1:0] mem_d [2];
  logic          wr_ptr_q, wr_ptr_d;
  logic          rd_ptr_q, rd_ptr_d;
  logic [1:0]    cnt_q, cnt_d;
  logic          push_en, pop_en;

  assign pop_en  = pop && (cnt_q != 2'd0);
  // A push while full would land on the slot being read; the caller's in_ready prevents it.
  assign push_en = push && (cnt_q != 2'd2);

  always_comb begin
    mem_d[0] = mem_q[0];
    mem_d[1] = mem_q[1];
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (push_en) begin
      mem_d[wr_ptr_q] = push_dat;
      wr_ptr_d        = ~wr_ptr_q;
    end
    if (pop_en) begin
      rd_ptr_d = ~rd_ptr_q;
    end
    case ({push_en, pop_en})
      2'b10:   cnt_d = cnt_q + 2'd1;
      2'b01:   cnt_d = cnt_q - 2'd1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      cnt_q    <= 2'd0;
    end else begin
      mem_q[0] <= mem_d[0];
      mem_q[1] <= mem_d[1];
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  assign head_dat = mem_q[rd_ptr_q];
  assign count    = cnt_q;
endmodule

module param_pack_stage #(
  parameter int W     = 4,
  parameter int RATIO = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  param_pack_stage_if.slave   bus
);
  localparam int OW = W * RATIO;
  localparam int CW = $clog2(RATIO + 1);
  localparam int EW = 1 + CW + OW;

  typedef struct packed {
    logic          last;
    logic [CW-1:0] lanes;
    logic [OW-1:0] data;
  } entry_t;

  logic [OW-1:0] acc_q, acc_d;
  logic [CW-1:0] acc_cnt_q, acc_cnt_d;
  // Holds in_ready low while in reset and releases it one edge after rst_n rises.
  logic          live_q, live_d;

  logic [OW-1:0] acc_merged;
  logic          in_ready_int;
  logic          accept;
  logic          complete;
  logic          pop;
  logic [1:0]    fifo_cnt;
  entry_t        push_ent;
  entry_t        head_ent;
  logic [EW-1:0] head_bits;

  assign in_ready_int = live_q && (fifo_cnt != 2'd2);
  assign accept       = bus.in_valid && in_ready_int;
  assign complete     = accept && ((acc_cnt_q == CW'(RATIO - 1)) || bus.in_last);
  assign pop          = (fifo_cnt != 2'd0) && bus.out_ready;

  always_comb begin
    acc_merged = acc_q;
    acc_merged[int'(acc_cnt_q) * W +: W] = bus.in_data;
  end

  always_comb begin
    live_d    = 1'b1;
    acc_d     = acc_q;
    acc_cnt_d = acc_cnt_q;
    if (accept) begin
      if (complete) begin
        acc_d     = '0;
        acc_cnt_d = '0;
      end else begin
        acc_d     = acc_merged;
        acc_cnt_d = acc_cnt_q + CW'(1);
      end
    end
  end

  always_comb begin
    push_ent.last  = bus.in_last;
    // acc_cnt_q + 1 never exceeds RATIO, so CW bits always hold it.
    push_ent.lanes = acc_cnt_q + CW'(1);
    push_ent.data  = acc_merged;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q     <= '0;
      acc_cnt_q <= '0;
      live_q    <= 1'b0;
    end else begin
      acc_q     <= acc_d;
      acc_cnt_q <= acc_cnt_d;
      live_q    <= live_d;
    end
  end

  pp_fifo2 #(.DW(EW)) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (complete),
    .push_dat (push_ent),
    .pop      (pop),
    .head_dat (head_bits),
    .count    (fifo_cnt)
  );

  assign head_ent      = head_bits;
  assign bus.in_ready  = in_ready_int;
  assign bus.out_valid = (fifo_cnt != 2'd0);
  assign bus.out_data  = head_ent.data;
  assign bus.out_lanes = head_ent.lanes;
  assign bus.out_last  = head_ent.last;
endmodule

// File: tb/tb_param_pack_stage.sv
module tb_param_pack_stage;
  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  param_pack_stage_if #(.W(4), .RATIO(2)) ifa ();
  param_pack_stage_if #(.W(8), .RATIO(3)) ifb ();

  param_pack_stage #(.W(4), .RATIO(2)) dut_a (.clk(clk), .rst_n(rst_n), .bus(ifa));
  param_pack_stage #(.W(8), .RATIO(3)) dut_b (.clk(clk), .rst_n(rst_n), .bus(ifb));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       v;
    logic [3:0] d;
    logic       l;
    logic       ordy;
    logic       e_ir;
    logic       e_ov;
    logic [7:0] e_dat;
    logic [1:0] e_lanes;
    logic       e_last;
  } vec_t;

  vec_t tbl [24];

  function automatic vec_t mk(logic v, logic [3:0] d, logic l, logic ordy,
                              logic e_ir, logic e_ov, logic [7:0] e_dat,
                              logic [1:0] e_lanes, logic e_last);
    vec_t r;
    r.v = v; r.d = d; r.l = l; r.ordy = ordy;
    r.e_ir = e_ir; r.e_ov = e_ov; r.e_dat = e_dat; r.e_lanes = e_lanes; r.e_last = e_last;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", name, got, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    // Rows: inputs applied this cycle; expectations describe outputs before those inputs act.
    tbl[0]  = mk(1, 4'hA, 0, 1,  1, 0, 8'h00, 2'd0, 0);
    tbl[1]  = mk(1, 4'h5, 0, 1,  1, 0, 8'h00, 2'd0, 0);
    tbl[2]  = mk(1, 4'h3, 1, 1,  1, 1, 8'h5A, 2'd2, 0);
    tbl[3]  = mk(0, 4'h0, 0, 1,  1, 1, 8'h03, 2'd1, 1);
    tbl[4]  = mk(0, 4'h0, 0, 0,  1, 0, 8'h00, 2'd0, 0);
    tbl[5]  = mk(1, 4'h1, 0, 0,  1, 0, 8'h00, 2'd0, 0);
    tbl[6]  = mk(1, 4'h2, 0, 0,  1, 0, 8'h00, 2'd0, 0);
    tbl[7]  = mk(1, 4'h3, 0, 0,  1, 1, 8'h21, 2'd2, 0);
    tbl[8]  = mk(1, 4'h4, 0, 0,  1, 1, 8'h21, 2'd2, 0);
    tbl[9]  = mk(1, 4'h5, 0, 0,  0, 1, 8'h21, 2'd2, 0);
    tbl[10] = mk(1, 4'h5, 0, 0,  0, 1, 8'h21, 2'd2, 0);
    tbl[11] = mk(1, 4'h5, 0, 1,  0, 1, 8'h21, 2'd2, 0);
    tbl[12] = mk(1, 4'h5, 0, 0,  1, 1, 8'h43, 2'd2, 0);
    tbl[13] = mk(1, 4'h6, 0, 0,  1, 1, 8'h43, 2'd2, 0);
    tbl[14] = mk(0, 4'h0, 0, 1,  0, 1, 8'h43, 2'd2, 0);
    tbl[15] = mk(0, 4'h0, 0, 1,  1, 1, 8'h65, 2'd2, 0);
    tbl[16] = mk(0, 4'h0, 0, 0,  1, 0, 8'h00, 2'd0, 0);
    tbl[17] = mk(1, 4'h7, 0, 0,  1, 0, 8'h00, 2'd0, 0);
    tbl[18] = mk(1, 4'h8, 0, 0,  1, 0, 8'h00, 2'd0, 0);
    tbl[19] = mk(1, 4'h9, 0, 0,  1, 1, 8'h87, 2'd2, 0);
    tbl[20] = mk(1, 4'hA, 0, 1,  1, 1, 8'h87, 2'd2, 0);
    tbl[21] = mk(0, 4'h0, 0, 0,  1, 1, 8'hA9, 2'd2, 0);
    tbl[22] = mk(0, 4'h0, 0, 1,  1, 1, 8'hA9, 2'd2, 0);
    tbl[23] = mk(0, 4'h0, 0, 0,  1, 0, 8'h00, 2'd0, 0);

    // Reset with a beat pending on the narrow side.
    rst_n         = 1'b0;
    ifa.in_valid  = 1'b1;
    ifa.in_data   = 4'hF;
    ifa.in_last   = 1'b0;
    ifa.out_ready = 1'b0;
    ifb.in_valid  = 1'b0;
    ifb.in_data   = 8'h00;
    ifb.in_last   = 1'b0;
    ifb.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst in_ready",  32'(ifa.in_ready),  32'd0);
    chk("rst out_valid", 32'(ifa.out_valid), 32'd0);
    chk("rst out_data",  32'(ifa.out_data),  32'd0);
    chk("rst out_lanes", 32'(ifa.out_lanes), 32'd0);
    chk("rst out_last",  32'(ifa.out_last),  32'd0);
    chk("rst b out_valid", 32'(ifb.out_valid), 32'd0);
    ifa.in_valid = 1'b0;
    rst_n        = 1'b1;
    tick();
    chk("post-rst in_ready",   32'(ifa.in_ready),  32'd1);
    chk("post-rst out_valid",  32'(ifa.out_valid), 32'd0);
    chk("post-rst b in_ready", 32'(ifb.in_ready),  32'd1);

    // Packing, flush, backpressure, simultaneous push/pop.
    for (int i = 0; i < 24; i++) begin
      chk($sformatf("row%0d in_ready", i),  32'(ifa.in_ready),  32'(tbl[i].e_ir));
      chk($sformatf("row%0d out_valid", i), 32'(ifa.out_valid), 32'(tbl[i].e_ov));
      if (tbl[i].e_ov) begin
        chk($sformatf("row%0d out_data", i),  32'(ifa.out_data),  32'(tbl[i].e_dat));
        chk($sformatf("row%0d out_lanes", i), 32'(ifa.out_lanes), 32'(tbl[i].e_lanes));
        chk($sformatf("row%0d out_last", i),  32'(ifa.out_last),  32'(tbl[i].e_last));
      end
      ifa.in_valid  = tbl[i].v;
      ifa.in_data   = tbl[i].d;
      ifa.in_last   = tbl[i].l;
      ifa.out_ready = tbl[i].ordy;
      tick();
    end

    // Reset in the middle of a word discards the partial lane.
    ifa.in_valid  = 1'b1;
    ifa.in_data   = 4'h7;
    ifa.in_last   = 1'b0;
    ifa.out_ready = 1'b0;
    tick();
    ifa.in_valid = 1'b0;
    rst_n        = 1'b0;
    #1;
    chk("midrst in_ready", 32'(ifa.in_ready), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("midrst rel in_ready",  32'(ifa.in_ready),  32'd1);
    chk("midrst rel out_valid", 32'(ifa.out_valid), 32'd0);
    ifa.in_valid = 1'b1;
    ifa.in_data  = 4'h8;
    tick();
    ifa.in_data = 4'h9;
    tick();
    ifa.in_valid = 1'b0;
    chk("midrst out_valid", 32'(ifa.out_valid), 32'd1);
    chk("midrst out_data",  32'(ifa.out_data),  32'h98);
    chk("midrst out_lanes", 32'(ifa.out_lanes), 32'd2);
    ifa.out_ready = 1'b1;
    tick();
    chk("midrst drained", 32'(ifa.out_valid), 32'd0);

    // W=8, RATIO=3 instance: full word, then a one-lane flush overlapping a pop.
    ifb.in_valid = 1'b1;
    ifb.in_data  = 8'h11;
    tick();
    ifb.in_data = 8'h22;
    tick();
    chk("b partial out_valid", 32'(ifb.out_valid), 32'd0);
    ifb.in_data = 8'h33;
    tick();
    chk("b out_valid", 32'(ifb.out_valid), 32'd1);
    chk("b out_data",  32'(ifb.out_data),  32'h332211);
    chk("b out_lanes", 32'(ifb.out_lanes), 32'd3);
    chk("b out_last",  32'(ifb.out_last),  32'd0);
    ifb.in_data = 8'h44;
    ifb.in_last = 1'b1;
    tick();
    ifb.in_valid = 1'b0;
    ifb.in_last  = 1'b0;
    chk("b flush out_valid", 32'(ifb.out_valid), 32'd1);
    chk("b flush out_data",  32'(ifb.out_data),  32'h000044);
    chk("b flush out_lanes", 32'(ifb.out_lanes), 32'd1);
    chk("b flush out_last",  32'(ifb.out_last),  32'd1);
    tick();
    chk("b drained", 32'(ifb.out_valid), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/param_pack_stage.md
Name: param_pack_stage

Overview:
- Gearbox feeding wide-port parameterized consumers: it collects RATIO narrow W-bit beats into one OW-bit word (OW = W*RATIO).
- Finished words are buffered in a 2-entry output FIFO with a valid/ready handshake.
- An early in_last flushes a partial word and reports how many lanes are valid.
- Sits directly upstream of any stage whose input width is derived from W.

Parameters:
- W, 4, input beat width in bits; legal range ≥1.
- RATIO, 2, beats per output word; legal range ≥1.
- OW, W*RATIO, localparam: output word width.
- CW, $clog2(RATIO+1), localparam: width of the lane count.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  input beat valid
- in_ready  output  1  stage can accept a beat
- in_data  input  W  input beat
- in_last  input  1  final beat of a packet; forces a flush
- out_valid  output  1  FIFO head valid
- out_ready  input  1  downstream accepts the head
- out_data  output  OW  packed word; lane k occupies bits [k*W +: W]
- out_lanes  output  CW  valid lanes in out_data (1..RATIO)
- out_last  output  1  word closes a packet

Behaviour:
- Reset (asynchronous assert, synchronous release):
  - acc_cnt=0, acc register=0.
  - FIFO empty; out_valid=0, out_data=0, out_lanes=0, out_last=0.
  - in_ready=0 while rst_n=0; in_ready=1 on the first cycle after release.
- Input accept (acc = in_valid && in_ready):
  - in_data is written into lane acc_cnt of the acc register.
  - acc_cnt increments.
- Completion: the accepted beat is beat RATIO-1, or in_last=1.
  - {acc register with the new lane merged, lanes=acc_cnt+1, last=in_last} is pushed into the FIFO in the same cycle.
  - acc_cnt returns to 0 and the acc register clears to 0.
  - Unfilled lanes of a partial word are 0.
- Latency: completing beat accepted at edge N → out_valid=1 after edge N (one cycle).
- in_ready = FIFO count < 2. It is registered-state only; there is no combinational path from out_ready.
- A non-completing beat is accepted whenever in_ready=1, even though only the completing beat needs FIFO space.
- Output: out_valid = FIFO count != 0.
  - out_data, out_lanes and out_last present the head entry.
  - Pop on out_valid && out_ready.
  - Head fields are held stable while out_valid=1 and out_ready=0.
- Push and pop in the same cycle: FIFO count unchanged. Entries stay ordered; the push never overwrites the entry being popped.
- FIFO pointers are 1-bit read/write indices that wrap 1→0. Count is 0..2.
- RATIO=1: every accepted beat completes; out_lanes is always 1.
- Beat with in_valid=1 and in_ready=0: not accepted, no state change. The upstream must hold the beat.
- Reset asserted mid-word or with a full FIFO: all state is discarded immediately; no partial word is emitted after release.
- out_lanes arithmetic is CW bits wide and never wraps, because acc_cnt+1 ≤ RATIO.

Test Plan:
All cases use W=4, RATIO=2 unless noted.
1. Reset check: hold rst_n=0 for 3 cycles with in_valid=1 → out_valid=0, in_ready=0, out_data=0; after release in_ready=1.
2. Basic packing:
   - Send 0xA then 0x5, out_ready=1 → one cycle after the second beat, out_data=0x5A, out_lanes=2, out_last=0.
   - Send 0x3 with in_last=1 → out_data=0x03, out_lanes=1, out_last=1.
3. Backpressure:
   - out_ready=0; send 6 beats 0x1..0x6 → two words 0x21 and 0x43 are buffered, and in_ready=0 after the 4th beat.
   - Beat 0x5 stalls while in_ready=0 and is accepted after the first pop; beat 0x6 is then accepted, so 0x65 enters the FIFO when the third word completes.
   - Raise out_ready → words arrive in the order 0x21, 0x43, 0x65, with no loss or duplication.
4. Simultaneous push and pop: with the FIFO holding 1 entry and out_ready=1, complete a word in the same cycle → count stays 1 and the next head is the newly pushed word.
5. Reset mid-operation:
   - Accept 0x7 (partial word), assert rst_n=0 for 1 cycle, release.
   - Send 0x8 then 0x9 → out_data=0x98; 0x7 never appears.
6. Width scaling with W=8, RATIO=3: send 0x11, 0x22, 0x33 → out_data=0x332211, out_lanes=3.
